reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter STOP_PC, default 32'h00000048, PC value that triggers the register dump.
REQ-002 Parameter MAX_CYCLES, default 1000, run-cycle limit before a forced (timeout) dump.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous and active-low.
REQ-005 Port pc_in  input  32  current PC of the single-cycle CPU.
REQ-006 Port instr_in  input  32  current instruction of the single-cycle CPU.
REQ-007 Port reg_sel  output  5  register-file debug read select; drives the CPU's reg_sel.
REQ-008 Port reg_data  input  32  register-file debug read data, combinational from reg_sel.
REQ-009 Port halt  output  1  CPU freeze request, high from trigger until reset.
REQ-010 Port out_valid  output  1  dump word valid.
REQ-011 Port out_ready  input  1  consumer ready; transfer when out_valid and out_ready are both high at a rising edge.
REQ-012 Port out_data  output  32  dump word.
REQ-013 Port out_last  output  1  high with the final dump word.
REQ-014 Port done  output  1  dump complete, sticky.
REQ-015 Port timeout  output  1  dump was forced by MAX_CYCLES, sticky.

Function
REQ-016 States: RUN, EMIT, LOAD, DONE; the word index idx is 6 bits, range 0..33.
REQ-017 In RUN, the cycle counter increments once per clock and saturates at MAX_CYCLES.
REQ-018 Trigger occurs at a RUN edge where pc_in==STOP_PC: latch pc_in and instr_in, set halt=1, idx=0, then go to EMIT with out_valid=1 and out_data=latched PC.
REQ-019 Timeout occurs at a RUN edge where the counter==MAX_CYCLES-1 and there is no trigger; it does the same as trigger and also sets timeout=1.
REQ-020 If trigger and timeout coincide, trigger wins and timeout stays 0.
REQ-021 Dump order: idx 0 = PC, idx 1 = instr, idx 2..33 = rf[idx-2]; 34 words total.
REQ-022 In EMIT, out_valid stays high and out_data/out_last stay stable until transfer; changes while stalled are forbidden.
REQ-023 On transfer of idx 0, idx becomes 1, out_data becomes the latched instr, and the FSM stays in EMIT with out_valid held high (back-to-back).
REQ-024 On transfer of idx 1..32: out_valid=0, reg_sel=idx-1 (registered), idx increments, and the FSM goes to LOAD.
REQ-025 LOAD lasts exactly 1 cycle: out_data=reg_data, out_valid=1, then EMIT; each register word therefore has a minimum spacing of 2 cycles.
REQ-026 Word idx 2 (rf[0]) outputs 32'h0 regardless of reg_data.
REQ-027 out_last=1 only while idx==33.
REQ-028 On transfer of idx 33: out_valid=0, out_last=0, done=1, then DONE.
REQ-029 DONE is terminal until rstn; pc_in, instr_in, and out_ready are ignored; halt stays 1.
REQ-030 pc_in and instr_in are ignored outside RUN.

Reset
REQ-031 rstn low asynchronously forces RUN, counter=0, idx=0, reg_sel=0, out_data=0, out_valid=0, out_last=0, halt=0, done=0, timeout=0.
REQ-032 Reset asserted mid-dump aborts immediately: out_valid drops in the same instant, and no partial word is completed.
REQ-033 After rstn deasserts, the first counted cycle is the first rising edge.

Verification
REQ-034 pc_in reaches 32'h48 on cycle 10, out_ready held 1, rf[i]=i*16 -> words 00000048, instr, 0, 10, 20, ..., 1F0; out_last on word 34; done=1; timeout=0.
REQ-035 pc_in never equals STOP_PC, MAX_CYCLES=20 -> dump starts after edge 20, timeout=1, and the first word is pc_in sampled at that edge.
REQ-036 out_ready toggles 1-0-0-1 repeatedly -> the word sequence matches REQ-034, and out_data/out_last stay stable through every stall.
REQ-037 rstn pulses low during word 12 -> all outputs are 0 at once; after release, the counter restarts and a retrigger produces a full 34-word dump.
REQ-038 pc_in==STOP_PC on the same edge as the counter limit -> timeout=0 and the dump proceeds normally.
REQ-039 reg_data forced to FFFFFFFF while sel=0 -> word 3 is 00000000.

Source files
------------

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - halts a single-cycle CPU at a stop PC or cycle limit and streams PC, instr and rf[0..31]
module reg_dump_ctrl #(
  parameter logic [31:0] STOP_PC    = 32'h00000048,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done,
  output logic        timeout
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_CYCLES - 1);
  localparam logic [5:0]    IDX_RF0  = 6'd2;
  localparam logic [5:0]    IDX_LAST = 6'd33;

  typedef enum logic [1:0] {RUN, EMIT, LOAD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    idx;
  logic [31:0]   instr_q;
  logic          trig;
  logic          tmo;
  logic          xfer;

  assign trig = (pc_in == STOP_PC);
  assign tmo  = (cnt == CNT_LIM);
  assign xfer = out_valid && out_ready;

  // idx always names the word currently presented on out_data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      cnt       <= '0;
      idx       <= '0;
      instr_q   <= '0;
      reg_sel   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      halt      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (trig || tmo) begin
            instr_q   <= instr_in;
            halt      <= 1'b1;
            idx       <= '0;
            out_data  <= pc_in;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            timeout   <= !trig;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (idx == 6'd0) begin
              idx      <= 6'd1;
              out_data <= instr_q;
            end else if (idx == IDX_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              // register words need a cycle for reg_data to follow reg_sel
              out_valid <= 1'b0;
              reg_sel   <= 5'(idx - 6'd1);
              idx       <= idx + 6'd1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          out_data  <= (idx == IDX_RF0) ? 32'h0 : reg_data;
          out_valid <= 1'b1;
          out_last  <= (idx == IDX_LAST);
          state     <= EMIT;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - directed self-checking bench for reg_dump_ctrl
module tb_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        halt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
  logic        timeout;

  logic [31:0] rf [32];
  logic [31:0] words [$];
  logic        lasts [$];
  int          viol;
  int          n_checks = 0;
  int          n_fail = 0;

  reg_dump_ctrl #(.STOP_PC(32'h00000048), .MAX_CYCLES(20)) dut (
    .clk(clk), .rstn(rstn), .pc_in(pc_in), .instr_in(instr_in),
    .reg_sel(reg_sel), .reg_data(reg_data), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;
  assign reg_data = rf[reg_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_valid"},   out_valid, 0);
    check({pfx, "_data"},    out_data,  0);
    check({pfx, "_last"},    out_last,  0);
    check({pfx, "_halt"},    halt,      0);
    check({pfx, "_done"},    done,      0);
    check({pfx, "_timeout"}, timeout,   0);
    check({pfx, "_reg_sel"}, reg_sel,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    out_ready = 1'b0;
    pc_in = 32'h0000_0000;
    instr_in = 32'h0;
    @(negedge clk);
    check_idle("rst");
    rstn = 1'b1;
  endtask

  // drives edges 1..n after reset release; pc hits STOP_PC on edge trig_edge
  task automatic run_to(input int n, input int trig_edge, input logic [31:0] pc_base,
                        input logic [31:0] instr_base);
    for (int k = 1; k <= n; k++) begin
      pc_in = (k == trig_edge) ? 32'h48 : pc_base + 32'(4 * k);
      instr_in = instr_base + 32'(k);
      @(negedge clk);
      if (k == n - 1) begin
        check("pre_valid", out_valid, 0);
        check("pre_halt", halt, 0);
      end
    end
    pc_in = 32'h48;
    instr_in = 32'hFFFF_FFFF;
  endtask

  task automatic capture(input bit stall, input int max_words);
    int budget;
    int cyc;
    logic [31:0] hd;
    logic hl;
    bit hv;
    logic rdy;
    budget = 600;
    cyc = 0;
    hv = 0;
    hd = '0;
    hl = 0;
    viol = 0;
    words.delete();
    lasts.delete();
    while (words.size() < max_words && budget > 0) begin
      if (hv && (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)) viol++;
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        words.push_back(out_data);
        lasts.push_back(out_last);
        hv = 0;
      end else begin
        hv = out_valid;
        hd = out_data;
        hl = out_last;
      end
      cyc++;
      budget--;
      @(negedge clk);
    end
    if (budget == 0) check("capture_budget", words.size(), max_words);
  endtask

  task automatic check_dump(input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                            input logic exp_tmo);
    logic [31:0] e;
    check("n_words", words.size(), 34);
    for (int i = 0; i < 34 && i < words.size(); i++) begin
      if (i == 0) e = exp_pc;
      else if (i == 1) e = exp_instr;
      else if (i == 2) e = 32'h0;
      else e = 32'((i - 2) * 16);
      check($sformatf("word%0d", i), words[i], e);
      check($sformatf("last%0d", i), lasts[i], (i == 33) ? 1 : 0);
    end
    check("end_done", done, 1);
    check("end_valid", out_valid, 0);
    check("end_last", out_last, 0);
    check("end_halt", halt, 1);
    check("end_timeout", timeout, exp_tmo);
    out_ready = 1'b1;
    pc_in = 32'h48;
    repeat (3) @(negedge clk);
    check("term_done", done, 1);
    check("term_valid", out_valid, 0);
    check("term_halt", halt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16);

    // trigger at cycle 10, ready held high
    do_reset();
    run_to(10, 10, 32'h1000, 32'hA000_0000);
    check("t1_valid", out_valid, 1);
    check("t1_halt", halt, 1);
    check("t1_first", out_data, 32'h48);
    check("t1_tmo", timeout, 0);
    capture(1'b0, 34);
    check_dump(32'h48, 32'hA000_000A, 1'b0);

    // forced dump at the cycle limit
    do_reset();
    run_to(20, 0, 32'h1000, 32'hB000_0000);
    check("t2_valid", out_valid, 1);
    check("t2_tmo", timeout, 1);
    check("t2_first", out_data, 32'h1050);
    capture(1'b0, 34);
    check_dump(32'h1050, 32'hB000_0014, 1'b1);

    // consumer stalls in a 1-0-0-1 pattern
    do_reset();
    run_to(3, 3, 32'h2000, 32'hC000_0000);
    capture(1'b1, 34);
    check("t3_stall_stable", viol, 0);
    check_dump(32'h48, 32'hC000_0003, 1'b0);

    // reset during word 12, then retrigger
    do_reset();
    run_to(5, 5, 32'h3000, 32'hD000_0000);
    capture(1'b0, 11);
    b = 0;
    while (!out_valid && b < 4) begin
      @(negedge clk);
      b++;
    end
    check("t4_w12_valid", out_valid, 1);
    check("t4_w12_data", out_data, 32'h90);
    out_ready = 1'b0;
    #2 rstn = 1'b0;
    #1 check_idle("abort");
    @(negedge clk);
    rstn = 1'b1;
    run_to(7, 7, 32'h3000, 32'hD100_0000);
    check("t4_retrig_valid", out_valid, 1);
    capture(1'b0, 34);
    check_dump(32'h48, 32'hD100_0007, 1'b0);

    // trigger coincides with the cycle limit
    do_reset();
    run_to(20, 20, 32'h5000, 32'hE000_0000);
    check("t5_valid", out_valid, 1);
    check("t5_tmo", timeout, 0);
    check("t5_first", out_data, 32'h48);
    capture(1'b0, 34);
    check_dump(32'h48, 32'hE000_0014, 1'b0);

    // rf[0] reads all-ones but must dump as zero
    rf[0] = 32'hFFFF_FFFF;
    do_reset();
    run_to(2, 2, 32'h6000, 32'hF000_0000);
    capture(1'b0, 34);
    check_dump(32'h48, 32'hF000_0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
